// File: rtl/echo_feedback_mixer.sv
// ============================================================================
// Module  : echo_feedback_mixer
// Brief   : Single-tap echo mixer; regenerates into an external delay line
//           and mixes the returned delayed sample with the dry input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module echo_feedback_mixer #(
   parameter int DATA_WIDTH     = 32,
   parameter int GAIN_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dry_valid,
   input  logic [DATA_WIDTH-1:0] dry_sample,
   input  logic [GAIN_WIDTH-1:0] feedback_gain,
   input  logic [GAIN_WIDTH-1:0] mix_gain,
   output logic                  dly_in_valid,
   output logic [DATA_WIDTH-1:0] dly_in_sample,
   input  logic                  dly_out_valid,
   input  logic [DATA_WIDTH-1:0] dly_out_sample,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_sample,
   output logic                  busy,
   output logic [15:0]           drop_count,
   output logic                  timeout_err
);

   localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] C_WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CALC  = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   state_t                state_q,         state_d;
   logic [DATA_WIDTH-1:0] dry_q,           dry_d;
   logic [GAIN_WIDTH-1:0] mix_gain_q,      mix_gain_d;
   logic [DATA_WIDTH-1:0] delayed_q,       delayed_d;
   logic [DATA_WIDTH-1:0] last_delayed_q,  last_delayed_d;
   logic [CW-1:0]         wait_cnt_q,      wait_cnt_d;
   logic                  dly_in_valid_q,  dly_in_valid_d;
   logic [DATA_WIDTH-1:0] dly_in_sample_q, dly_in_sample_d;
   logic                  out_valid_q,     out_valid_d;
   logic [DATA_WIDTH-1:0] out_sample_q,    out_sample_d;
   logic [15:0]           drop_count_q,    drop_count_d;
   logic                  timeout_err_q,   timeout_err_d;

   logic signed [PW-1:0]         fb_prod;
   logic signed [PW-1:0]         mix_prod;
   logic signed [DATA_WIDTH:0]   fb_sum;
   logic signed [DATA_WIDTH:0]   mix_sum;
   logic [DATA_WIDTH-1:0]        fb_sat;
   logic [DATA_WIDTH-1:0]        mix_sat;
   logic                         unused_frac;

   function automatic logic [DATA_WIDTH-1:0] sat(input logic [DATA_WIDTH:0] s);
      if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
         return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
      return s[DATA_WIDTH-1:0];
   endfunction

   // Signed sample times zero-extended gain; dropping the low GAIN_WIDTH
   // bits of the product is the flooring arithmetic shift.
   always_comb begin
      fb_prod  = $signed({{(GAIN_WIDTH+1){last_delayed_q[DATA_WIDTH-1]}}, last_delayed_q})
               * $signed({{(DATA_WIDTH+1){1'b0}}, feedback_gain});
      mix_prod = $signed({{(GAIN_WIDTH+1){delayed_q[DATA_WIDTH-1]}}, delayed_q})
               * $signed({{(DATA_WIDTH+1){1'b0}}, mix_gain_q});
      fb_sum   = $signed({dry_sample[DATA_WIDTH-1], dry_sample})
               + $signed(fb_prod[PW-1:GAIN_WIDTH]);
      mix_sum  = $signed({dry_q[DATA_WIDTH-1], dry_q})
               + $signed(mix_prod[PW-1:GAIN_WIDTH]);
      fb_sat   = sat(fb_sum);
      mix_sat  = sat(mix_sum);
      unused_frac = ^{fb_prod[GAIN_WIDTH-1:0], mix_prod[GAIN_WIDTH-1:0]};
   end

   always_comb begin
      state_d         = state_q;
      dry_d           = dry_q;
      mix_gain_d      = mix_gain_q;
      delayed_d       = delayed_q;
      last_delayed_d  = last_delayed_q;
      wait_cnt_d      = wait_cnt_q;
      dly_in_valid_d  = 1'b0;
      dly_in_sample_d = dly_in_sample_q;
      out_valid_d     = 1'b0;
      out_sample_d    = out_sample_q;
      drop_count_d    = drop_count_q;
      timeout_err_d   = timeout_err_q;

      if (dry_valid && (state_q != ST_IDLE) && (drop_count_q != 16'hFFFF)) begin
         drop_count_d = drop_count_q + 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            // The regeneration sum is formed on the accept edge so the
            // write strobe and its sample appear together in ISSUE.
            if (dry_valid) begin
               dry_d           = dry_sample;
               mix_gain_d      = mix_gain;
               dly_in_sample_d = fb_sat;
               dly_in_valid_d  = 1'b1;
               state_d         = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (dly_out_valid) begin
               delayed_d      = dly_out_sample;
               last_delayed_d = dly_out_sample;
               state_d        = ST_CALC;
            end else if (wait_cnt_q == C_WAIT_LAST) begin
               delayed_d      = '0;
               last_delayed_d = '0;
               timeout_err_d  = 1'b1;
               state_d        = ST_CALC;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         ST_CALC: begin
            out_sample_d = mix_sat;
            out_valid_d  = 1'b1;
            state_d      = ST_OUT;
         end
         ST_OUT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         dry_q           <= '0;
         mix_gain_q      <= '0;
         delayed_q       <= '0;
         last_delayed_q  <= '0;
         wait_cnt_q      <= '0;
         dly_in_valid_q  <= 1'b0;
         dly_in_sample_q <= '0;
         out_valid_q     <= 1'b0;
         out_sample_q    <= '0;
         drop_count_q    <= '0;
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         dry_q           <= dry_d;
         mix_gain_q      <= mix_gain_d;
         delayed_q       <= delayed_d;
         last_delayed_q  <= last_delayed_d;
         wait_cnt_q      <= wait_cnt_d;
         dly_in_valid_q  <= dly_in_valid_d;
         dly_in_sample_q <= dly_in_sample_d;
         out_valid_q     <= out_valid_d;
         out_sample_q    <= out_sample_d;
         drop_count_q    <= drop_count_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   assign dly_in_valid  = dly_in_valid_q;
   assign dly_in_sample = dly_in_sample_q;
   assign out_valid     = out_valid_q;
   assign out_sample    = out_sample_q;
   assign busy          = (state_q != ST_IDLE);
   assign drop_count    = drop_count_q;
   assign timeout_err   = timeout_err_q;

endmodule

`default_nettype wire

// File: doc/echo_feedback_mixer.md
ECHO_FEEDBACK_MIXER -- requirements
Module: echo_feedback_mixer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, two's-complement width of all sample ports.
REQ-002 Parameter GAIN_WIDTH, default 16, width of unsigned Q0.GAIN_WIDTH gain ports (gain = code / 2^GAIN_WIDTH).
REQ-003 Parameter TIMEOUT_CYCLES, default 15, maximum cycles spent waiting for the delayed-sample return.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 dry_valid  in  1  one-cycle strobe, new dry sample.
REQ-007 dry_sample  in  DATA_WIDTH  signed dry input.
REQ-008 feedback_gain  in  GAIN_WIDTH  echo regeneration gain, sampled with dry_valid.
REQ-009 mix_gain  in  GAIN_WIDTH  wet level in output, sampled with dry_valid.
REQ-010 dly_in_valid  out  1  write strobe to delay line sample_valid.
REQ-011 dly_in_sample  out  DATA_WIDTH  signed sample written into delay line.
REQ-012 dly_out_valid  in  1  delay line read-return strobe.
REQ-013 dly_out_sample  in  DATA_WIDTH  signed delayed sample returned.
REQ-014 out_valid  out  1  one-cycle strobe, mixed sample ready.
REQ-015 out_sample  out  DATA_WIDTH  signed mixed output.
REQ-016 busy  out  1  high whenever FSM not IDLE.
REQ-017 drop_count  out  16  saturating count of dry samples dropped while busy.
REQ-018 timeout_err  out  1  sticky flag, a delayed-sample return timed out.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, CALC, OUT; busy SHALL equal (state != IDLE).
REQ-020 IDLE: dry_valid high -> capture dry_sample, feedback_gain, mix_gain; next ISSUE.
REQ-021 ISSUE (one cycle): dly_in_valid high; dly_in_sample = sat(dry + floor(feedback_gain * last_delayed / 2^GAIN_WIDTH)); next WAIT; wait counter cleared.
REQ-022 dly_in_valid SHALL be high only in the ISSUE cycle; dly_in_sample holds its value until next ISSUE.
REQ-023 WAIT: dly_out_valid high -> capture dly_out_sample into last_delayed and working register; next CALC.
REQ-024 WAIT: after TIMEOUT_CYCLES consecutive cycles without dly_out_valid -> working delayed value = 0, last_delayed = 0, timeout_err set; next CALC.
REQ-025 dly_out_valid outside WAIT SHALL be ignored (no state or register change).
REQ-026 CALC (one cycle): register mix = sat(dry + floor(mix_gain * delayed / 2^GAIN_WIDTH)); next OUT.
REQ-027 OUT (one cycle): out_valid high with out_sample = mix; next IDLE; out_sample holds until next OUT.
REQ-028 Latency: out_valid high exactly 2 cycles after the edge sampling dly_out_valid; dly_in_valid high exactly 1 cycle after edge sampling dry_valid.
REQ-029 Products: signed sample x unsigned gain, full width DATA_WIDTH+GAIN_WIDTH+1, arithmetic right shift by GAIN_WIDTH (floor); sums DATA_WIDTH+1 bits.
REQ-030 sat(): clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-031 dry_valid while busy SHALL be dropped (no capture, no extra dly_in_valid) and increment drop_count, saturating at 0xFFFF.
REQ-032 dry_valid in the same cycle as OUT SHALL be dropped; dry_valid in the cycle after OUT (IDLE) SHALL be accepted.

Reset
REQ-033 rst high: state IDLE; dly_in_valid, out_valid, busy, timeout_err = 0; dly_in_sample, out_sample, last_delayed, drop_count, wait counter = 0.
REQ-034 rst SHALL override every state including mid-WAIT; a return arriving after reset release SHALL be ignored per REQ-025.

Verification (DATA_WIDTH=16, GAIN_WIDTH=16, responder returns dly_out_valid 4 cycles after dly_in_valid)
REQ-035 Reset: assert rst 2 cycles -> all outputs 0, busy 0, drop_count 0.
REQ-036 Basic echo: dry=1000, fb=0x8000, mix=0x8000, responder returns 400 -> dly_in_sample=1000, out_sample=1200; next dry=0 -> dly_in_sample=200.
REQ-037 Saturation: dry=28672, return 28672, mix=0xFFFF -> out_sample=32767; dry=-32768, return -32768, mix=0xFFFF -> out_sample=-32768.
REQ-038 Timeout: dry=500, no return -> after 15 WAIT cycles timeout_err=1, out_sample=500; next ISSUE with fb=0xFFFF uses last_delayed=0.
REQ-039 Drop: dry_valid pulse during WAIT and during OUT -> drop_count=2, single dly_in_valid, single out_valid.
REQ-040 Reset mid-WAIT: rst during WAIT, return strobe after release -> no out_valid, busy 0, last_delayed 0.
